// File: rtl/alu_arith.sv
// Registered arithmetic unit: CLA add/sub with NZCV flags and a start/done handshake.
// Define ALU_MUL_EN to build the sequential shift-add multiplier for opcodes 100/101.
module alu_arith #(
   parameter int WIDTH     = 8,
   parameter int CLA_GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out_result,
   output logic             cout,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);
   localparam int NGRP = WIDTH / CLA_GROUP;

   logic [WIDTH-1:0] addend, gen, prop, sum;
   logic             carry0, add_cout, add_ovf, accept;

   logic             done_reg, done_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic             cout_reg, cout_next, ovf_reg, ovf_next;
   logic             zero_reg, zero_next, neg_reg, neg_next;
   logic             load;

   // SUB/SBC add the inverted operand; the carry-in is 1 for SUB and cin for ADC/SBC.
   assign addend = op[1] ? ~in_b : in_b;
   assign carry0 = op[0] ? cin : op[1];
   assign gen    = in_a & addend;
   assign prop   = in_a ^ addend;

   // Lookahead inside each group, group carries rippled between groups.
   always_comb begin
      logic grp_cin, grp_cout, cbit, chain;
      sum      = '0;
      grp_cin  = carry0;
      grp_cout = 1'b0;
      for (int g = 0; g < NGRP; g++) begin
         grp_cout = 1'b0;
         for (int k = 0; k <= CLA_GROUP; k++) begin
            cbit  = 1'b0;
            chain = 1'b1;
            for (int j = k - 1; j >= 0; j--) begin
               cbit  = cbit | (chain & gen[g*CLA_GROUP + j]);
               chain = chain & prop[g*CLA_GROUP + j];
            end
            cbit = cbit | (chain & grp_cin);
            if (k < CLA_GROUP)
               sum[g*CLA_GROUP + k] = prop[g*CLA_GROUP + k] ^ cbit;
            else
               grp_cout = cbit;
         end
         grp_cin = grp_cout;
      end
      add_cout = grp_cin;
   end

   assign add_ovf = (in_a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);

`ifdef ALU_MUL_EN
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic {IDLE, MUL} state_t;

   state_t               state_reg, state_next;
   logic [CW-1:0]        count_reg, count_next;
   logic [WIDTH-1:0]     mcand_reg, mcand_next, mplr_reg, mplr_next;
   logic [2*WIDTH-1:0]   prod_reg, prod_next, prod_step;
   logic                 high_reg, high_next;
   logic [WIDTH:0]       upper;

   assign busy  = (state_reg == MUL);
   assign upper = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + {1'b0, (mplr_reg[0] ? mcand_reg : '0)};
   assign prod_step = {upper, prod_reg[WIDTH-1:1]};
`else
   assign busy = 1'b0;
`endif

   assign accept = start && !busy;

   always_comb begin
      done_next   = 1'b0;
      load        = 1'b0;
      result_next = result_reg;
      cout_next   = cout_reg;
      ovf_next    = ovf_reg;
`ifdef ALU_MUL_EN
      state_next  = state_reg;
      count_next  = count_reg;
      mcand_next  = mcand_reg;
      mplr_next   = mplr_reg;
      prod_next   = prod_reg;
      high_next   = high_reg;
`endif
      if (accept) begin
         case (op)
            3'b110: begin
               load = 1'b1; result_next = in_b; cout_next = 1'b0; ovf_next = 1'b0;
            end
            3'b111: begin
               load = 1'b1; result_next = in_a; cout_next = 1'b0; ovf_next = 1'b0;
            end
            3'b100, 3'b101: begin
`ifdef ALU_MUL_EN
               state_next = MUL;
               count_next = CW'(WIDTH);
               mcand_next = in_a;
               mplr_next  = in_b;
               prod_next  = '0;
               high_next  = op[0];
`else
               // Multiply not built: complete immediately, V marks the op unsupported.
               load = 1'b1; result_next = '0; cout_next = 1'b0; ovf_next = 1'b1;
`endif
            end
            default: begin
               load = 1'b1; result_next = sum; cout_next = add_cout; ovf_next = add_ovf;
            end
         endcase
      end
`ifdef ALU_MUL_EN
      else if (state_reg == MUL) begin
         prod_next  = prod_step;
         mplr_next  = mplr_reg >> 1;
         count_next = count_reg - 1'b1;
         if (count_reg == CW'(1)) begin
            state_next  = IDLE;
            load        = 1'b1;
            result_next = high_reg ? prod_step[2*WIDTH-1:WIDTH] : prod_step[WIDTH-1:0];
            cout_next   = (prod_step[2*WIDTH-1:WIDTH] != '0);
            ovf_next    = 1'b0;
         end
      end
`endif
      done_next = load;
      zero_next = load ? (result_next == '0) : zero_reg;
      neg_next  = load ? result_next[WIDTH-1] : neg_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done_reg   <= 1'b0;
         result_reg <= '0;
         cout_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
         zero_reg   <= 1'b0;
         neg_reg    <= 1'b0;
`ifdef ALU_MUL_EN
         state_reg  <= IDLE;
         count_reg  <= '0;
         mcand_reg  <= '0;
         mplr_reg   <= '0;
         prod_reg   <= '0;
         high_reg   <= 1'b0;
`endif
      end else begin
         done_reg   <= done_next;
         result_reg <= result_next;
         cout_reg   <= cout_next;
         ovf_reg    <= ovf_next;
         zero_reg   <= zero_next;
         neg_reg    <= neg_next;
`ifdef ALU_MUL_EN
         state_reg  <= state_next;
         count_reg  <= count_next;
         mcand_reg  <= mcand_next;
         mplr_reg   <= mplr_next;
         prod_reg   <= prod_next;
         high_reg   <= high_next;
`endif
      end
   end

   assign done       = done_reg;
   assign out_result = result_reg;
   assign cout       = cout_reg;
   assign zero       = zero_reg;
   assign neg        = neg_reg;
   assign ovf        = ovf_reg;
endmodule

// File: doc/alu_arith.md
Name: alu_arith

Overview:
- Parametrised, registered arithmetic unit for the accumulator datapath.
- Successor to the combinational 8-bit carry-lookahead adder.
- in_a comes from the accumulator, in_b from the bus; the result drives the bus and the flags drive the status register.
- Adds subtract/borrow ops, a full NZCV flag set, start/done handshake, and an optional multi-cycle shift-add multiplier.

Parameters:
WIDTH, 8, operand/result width in bits (>=4)
CLA_GROUP, 4, carry-lookahead group size for the add/sub path; must divide WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
op  input  3  operation code, latched on accept
in_a  input  WIDTH  operand A (accumulator), latched on accept
in_b  input  WIDTH  operand B (bus), latched on accept
cin  input  1  carry in (status register C), latched on accept
busy  output  1  multi-cycle op in progress
done  output  1  one-cycle pulse: out_result/flags updated this cycle
out_result  output  WIDTH  registered result
cout  output  1  carry flag C
zero  output  1  Z: out_result==0
neg  output  1  N: out_result[WIDTH-1]
ovf  output  1  V: signed overflow

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: busy=0, done=0, out_result=0, cout=0, zero=0, neg=0, ovf=0; the multiplier state is cleared.
- A reset during a multiply aborts it, with no done pulse.
- Accept: start=1 && busy=0 at a rising edge latches op, in_a, in_b, cin.
- start while busy=1 is ignored; it is neither queued nor errored.
- Opcodes:
  - 000 ADD: A+B
  - 001 ADC: A+B+cin
  - 010 SUB: A+~B+1
  - 011 SBC: A+~B+cin
  - 100 MULL: low WIDTH bits of A*B (unsigned)
  - 101 MULH: high WIDTH bits of A*B
  - 110 PASSB: B
  - 111 PASSA: A
- Carry convention: C = carry out of bit WIDTH-1, so for subtract C=1 means no borrow.
- V = (A[msb]==B'[msb]) && (R[msb]!=A[msb]), where B' is the effective addend (B or ~B).
- Add/sub is built from CLA groups of CLA_GROUP bits with rippled group carries.
- Single-cycle ops (000-011, 110, 111):
  - Result and flags are registered at the accept edge.
  - done=1 for the following cycle; busy stays 0, so back-to-back accepts every cycle are allowed.
  - PASSA/PASSB: C=0, V=0.
- Multiply (100/101), states IDLE -> MUL -> IDLE:
  - At accept: busy=1, product=0, count=WIDTH.
  - Each MUL cycle: if multiplier LSB, add multiplicand into the upper half; shift right; count--.
  - When count reaches 0: busy=0, out_result=selected half, done=1 for one cycle.
  - Accept-to-done latency: WIDTH+1 cycles.
  - Flags: C = (high half != 0), V=0; Z and N taken from the selected half.
- Between ops, out_result and the flags hold their last values; done=0 whenever no op completes.
- A start arriving in the same cycle as the multiply done pulse is accepted (busy is already 0).

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: opcodes 100/101 use the sequential multiplier as described.
- Undefined:
  - No multiplier logic is built.
  - Opcodes 100/101 complete as single-cycle ops: out_result=0, Z=1, N=0, C=0, V=1 (V flags "unsupported").
  - busy is tied to 0.

Test Plan:
- WIDTH=8, ADD 0xFF+0x01 -> next cycle: done=1, out_result=0x00, C=1, Z=1, N=0, V=0.
- ADD 0x7F+0x01 -> out_result=0x80, N=1, V=1, C=0; then ADC 0x10+0x20, cin=1 -> 0x31, all flags 0.
- SUB 0x05-0x07 -> 0xFE, C=0, N=1, V=0; SBC 0x05,0x03, cin=0 -> 0x01, C=1.
- ALU_MUL_EN defined:
  - MULL 200*3 -> busy high 8 cycles, done 9 cycles after accept, out_result=0x58, C=1.
  - MULH on the same operands -> 0x02.
  - A start while busy is ignored: result unchanged and exactly one done pulse.
- Reset asserted on the 4th MUL cycle -> next cycle busy=0, done=0, all outputs 0; a following ADD 0x01+0x01 -> 0x02.
- ALU_MUL_EN undefined: MULL 200*3 -> done after 1 cycle, out_result=0, Z=1, V=1, busy never asserted.
